// File: rtl/mem_ctrl_pkg.sv
// Shared widths, length encodings, controller states and ownership tags for the
// byte-wide RAM sequencer.
package mem_ctrl_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;

    localparam logic [1:0] MEM_LEN_BYTE = 2'd0;
    localparam logic [1:0] MEM_LEN_HALF = 2'd1;
    localparam logic [1:0] MEM_LEN_WORD = 2'd2;

    typedef enum logic [1:0] {
        MCS_IDLE,
        MCS_READ,
        MCS_WRITE,
        MCS_DONE
    } mcs_state_e;

    typedef enum logic {
        OWNER_IF,
        OWNER_MEM
    } owner_e;

    // Encodings 2 and 3 both mean a full word.
    function automatic logic [2:0] beat_count(input logic [1:0] len);
        case (len)
            MEM_LEN_BYTE: return 3'd1;
            MEM_LEN_HALF: return 3'd2;
            default:      return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// Sign/zero extension of an assembled little-endian load word by access length.
module mem_load_ext
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        len_i,
    input  logic              signed_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = word_i;
        case (len_i)
            MEM_LEN_BYTE: data_o = {{(DATA_W-8){signed_i & word_i[7]}}, word_i[7:0]};
            MEM_LEN_HALF: data_o = {{(DATA_W-16){signed_i & word_i[15]}}, word_i[15:0]};
            default:      data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-beat RAM sequencer shared between instruction fetch and the MEM stage;
// MEM requests win over IF, and each transaction ends with a one-cycle done pulse.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_clear_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_done_o,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              mem_signed_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_done_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    input  logic [7:0]        ram_din_i
);

    mcs_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        len_q, len_d;
    logic              signed_q, signed_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [DATA_W-1:0] ext_data;
    logic [2:0]        nbeats;
    logic [1:0]        byte_sel;

    assign nbeats   = beat_count(len_q);
    assign byte_sel = 2'(cnt_q - 3'd1);

    mem_load_ext #(
        .DATA_W(DATA_W)
    ) u_load_ext (
        .word_i  (buf_q),
        .len_i   (len_q),
        .signed_i(signed_q),
        .data_o  (ext_data)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= MCS_IDLE;
            owner_q  <= OWNER_IF;
            cnt_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            buf_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            buf_q    <= buf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        len_d       = len_q;
        signed_d    = signed_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        ram_a_o     = '0;
        ram_dout_o  = '0;
        ram_wr_o    = 1'b0;
        if_data_o   = '0;
        if_done_o   = 1'b0;
        mem_rdata_o = '0;
        mem_done_o  = 1'b0;

        case (state_q)
            MCS_IDLE: begin
                if (mem_write_i || mem_read_i) begin
                    owner_d  = OWNER_MEM;
                    addr_d   = mem_addr_i;
                    len_d    = mem_len_i;
                    signed_d = mem_signed_i;
                    wdata_d  = mem_wdata_i;
                    cnt_d    = '0;
                    buf_d    = '0;
                    state_d  = mem_write_i ? MCS_WRITE : MCS_READ;
                end else if (if_req_i && !if_clear_i) begin
                    owner_d  = OWNER_IF;
                    addr_d   = if_addr_i;
                    len_d    = MEM_LEN_WORD;
                    signed_d = 1'b0;
                    wdata_d  = '0;
                    cnt_d    = '0;
                    buf_d    = '0;
                    state_d  = MCS_READ;
                end
            end
            MCS_READ: begin
                if (owner_q == OWNER_IF && if_clear_i) begin
                    state_d = MCS_IDLE;
                end else begin
                    // RAM answers one cycle late, so beat k's byte lands while beat k+1 is addressed.
                    if (cnt_q < nbeats) begin
                        ram_a_o = addr_q + ADDR_W'(cnt_q);
                    end
                    if (cnt_q != 3'd0) begin
                        buf_d[8*byte_sel +: 8] = ram_din_i;
                    end
                    if (cnt_q == nbeats) begin
                        state_d = MCS_DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            MCS_WRITE: begin
                ram_a_o    = addr_q + ADDR_W'(cnt_q);
                ram_dout_o = wdata_q[8*cnt_q +: 8];
                ram_wr_o   = 1'b1;
                if (cnt_q == nbeats - 3'd1) begin
                    state_d = MCS_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            MCS_DONE: begin
                state_d = MCS_IDLE;
                if (owner_q == OWNER_MEM) begin
                    mem_done_o  = 1'b1;
                    mem_rdata_o = ext_data;
                end else if (!if_clear_i) begin
                    if_done_o = 1'b1;
                    if_data_o = buf_q;
                end
            end
            default: state_d = MCS_IDLE;
        endcase

        // Global stall: hold every register and suppress all side effects.
        if (!rdy_in) begin
            state_d     = state_q;
            owner_d     = owner_q;
            cnt_d       = cnt_q;
            addr_d      = addr_q;
            len_d       = len_q;
            signed_d    = signed_q;
            wdata_d     = wdata_q;
            buf_d       = buf_q;
            ram_wr_o    = 1'b0;
            if_done_o   = 1'b0;
            if_data_o   = '0;
            mem_done_o  = 1'b0;
            mem_rdata_o = '0;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a registered byte-wide RAM model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_clear = 1'b0;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        mem_signed = 1'b0;
    logic [1:0]  mem_len = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din = '0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram [0:65535];
    logic        pk_en = 1'b0;
    logic [15:0] pk_a = '0;
    logic [7:0]  pk_d = '0;
    int          wr_count = 0;

    mem_ctrl #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .rdy_in      (rdy),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_clear_i  (if_clear),
        .if_data_o   (if_data),
        .if_done_o   (if_done),
        .mem_read_i  (mem_read),
        .mem_write_i (mem_write),
        .mem_signed_i(mem_signed),
        .mem_len_i   (mem_len),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_rdata_o (mem_rdata),
        .mem_done_o  (mem_done),
        .ram_a_o     (ram_a),
        .ram_dout_o  (ram_dout),
        .ram_wr_o    (ram_wr),
        .ram_din_i   (ram_din)
    );

    always #5 clk = ~clk;

    // RAM frozen by rdy like the controller; all tested addresses are distinct in their low 16 bits.
    always @(posedge clk) begin
        if (pk_en) begin
            ram[pk_a] <= pk_d;
        end else if (rdy) begin
            ram_din <= ram[ram_a[15:0]];
            if (ram_wr) begin
                ram[ram_a[15:0]] <= ram_dout;
                wr_count <= wr_count + 1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        pk_a  = a[15:0];
        pk_d  = d;
        pk_en = 1'b1;
        tick();
        pk_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [104:0] outs;
        #1;
        outs = {if_done, mem_done, ram_wr, ram_a, ram_dout, if_data};
        checks++;
        if (outs !== '0 || mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got outs=%h rdata=%h, want all zero", outs, mem_rdata);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_word_read();
        poke(32'h100, 8'h13);
        poke(32'h101, 8'h05);
        poke(32'h102, 8'h00);
        poke(32'h103, 8'h00);
        if_req  = 1'b1;
        if_addr = 32'h100;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 4) begin
                checks++;
                if (ram_a !== 32'h100 + 32'(c - 1) || ram_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL word_read_addr c%0d: got a=%h wr=%b, want a=%h wr=0",
                             c, ram_a, ram_wr, 32'h100 + 32'(c - 1));
                end
            end
            checks++;
            if (if_done !== (c == 6)) begin
                errors++;
                $display("FAIL word_read_done c%0d: got %b, want %b", c, if_done, (c == 6));
            end
            if (c == 6) begin
                checks++;
                if (if_data !== 32'h00000513) begin
                    errors++;
                    $display("FAIL word_read_data: got %h, want 00000513", if_data);
                end
            end
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_byte_load(input logic sgn, input logic [31:0] exp);
        mem_read   = 1'b1;
        mem_signed = sgn;
        mem_len    = 2'd0;
        mem_addr   = 32'h2004;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if (ram_a !== 32'h2004) begin
                    errors++;
                    $display("FAIL byte_load_addr s%0d: got %h, want 00002004", sgn, ram_a);
                end
            end
            checks++;
            if (mem_done !== (c == 3)) begin
                errors++;
                $display("FAIL byte_load_done s%0d c%0d: got %b, want %b", sgn, c, mem_done, (c == 3));
            end
            if (c == 3) begin
                checks++;
                if (mem_rdata !== exp) begin
                    errors++;
                    $display("FAIL byte_load_data s%0d: got %h, want %h", sgn, mem_rdata, exp);
                end
            end
        end
        mem_read = 1'b0;
        tick();
    endtask

    task automatic test_half_store();
        int w0;
        poke(32'h12, 8'h55);
        w0 = wr_count;
        mem_write = 1'b1;
        mem_len   = 2'd1;
        mem_addr  = 32'h10;
        mem_wdata = 32'hDEADBEEF;
        tick();
        checks++;
        if (ram_wr !== 1'b1 || ram_a !== 32'h10 || ram_dout !== 8'hEF) begin
            errors++;
            $display("FAIL half_store_b0: got wr=%b a=%h d=%h, want 1 00000010 ef", ram_wr, ram_a, ram_dout);
        end
        tick();
        checks++;
        if (ram_wr !== 1'b1 || ram_a !== 32'h11 || ram_dout !== 8'hBE) begin
            errors++;
            $display("FAIL half_store_b1: got wr=%b a=%h d=%h, want 1 00000011 be", ram_wr, ram_a, ram_dout);
        end
        tick();
        checks++;
        if (mem_done !== 1'b1 || ram_wr !== 1'b0) begin
            errors++;
            $display("FAIL half_store_done: got done=%b wr=%b, want done=1 wr=0", mem_done, ram_wr);
        end
        mem_write = 1'b0;
        tick();
        tick();
        checks++;
        if (wr_count - w0 !== 2 || ram[16'h10] !== 8'hEF || ram[16'h11] !== 8'hBE || ram[16'h12] !== 8'h55) begin
            errors++;
            $display("FAIL half_store_ram: got writes=%0d ram10=%h ram11=%h ram12=%h, want 2 ef be 55",
                     wr_count - w0, ram[16'h10], ram[16'h11], ram[16'h12]);
        end
    endtask

    task automatic test_half_wrap();
        poke(32'hFFFFFFFF, 8'h34);
        poke(32'h00000000, 8'h92);
        mem_read   = 1'b1;
        mem_signed = 1'b1;
        mem_len    = 2'd1;
        mem_addr   = 32'hFFFFFFFF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 2) begin
                checks++;
                if (ram_a !== 32'h0) begin
                    errors++;
                    $display("FAIL wrap_addr: got %h, want 00000000", ram_a);
                end
            end
            checks++;
            if (mem_done !== (c == 4)) begin
                errors++;
                $display("FAIL wrap_done c%0d: got %b, want %b", c, mem_done, (c == 4));
            end
            if (c == 4) begin
                checks++;
                if (mem_rdata !== 32'hFFFF9234) begin
                    errors++;
                    $display("FAIL wrap_data: got %h, want ffff9234", mem_rdata);
                end
            end
        end
        mem_read = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        poke(32'h300, 8'h78);
        poke(32'h301, 8'h56);
        poke(32'h302, 8'h34);
        poke(32'h303, 8'h12);
        if_req     = 1'b1;
        if_addr    = 32'h300;
        mem_read   = 1'b1;
        mem_signed = 1'b1;
        mem_len    = 2'd0;
        mem_addr   = 32'h2004;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if (ram_a !== 32'h2004) begin
                    errors++;
                    $display("FAIL contention_mem_first: got a=%h, want 00002004", ram_a);
                end
            end
            checks++;
            if (mem_done !== (c == 3) || if_done !== (c == 10)) begin
                errors++;
                $display("FAIL contention_done c%0d: got mem=%b if=%b, want mem=%b if=%b",
                         c, mem_done, if_done, (c == 3), (c == 10));
            end
            if (c == 3) begin
                checks++;
                if (mem_rdata !== 32'hFFFFFF80) begin
                    errors++;
                    $display("FAIL contention_mem_data: got %h, want ffffff80", mem_rdata);
                end
                mem_read = 1'b0;
            end
            if (c == 4) begin
                checks++;
                if (ram_a !== 32'h0) begin
                    errors++;
                    $display("FAIL contention_gap: got a=%h, want 00000000", ram_a);
                end
            end
            if (c >= 5 && c <= 8) begin
                checks++;
                if (ram_a !== 32'h300 + 32'(c - 5)) begin
                    errors++;
                    $display("FAIL contention_if_addr c%0d: got %h, want %h", c, ram_a, 32'h300 + 32'(c - 5));
                end
            end
            if (c == 10) begin
                checks++;
                if (if_data !== 32'h12345678) begin
                    errors++;
                    $display("FAIL contention_if_data: got %h, want 12345678", if_data);
                end
                if_req = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_flush();
        if_req  = 1'b1;
        if_addr = 32'h100;
        tick();
        tick();
        if_clear = 1'b1;
        tick();
        if_clear = 1'b0;
        if_req   = 1'b0;
        #1;
        checks++;
        if (ram_a !== 32'h0 || if_done !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got a=%h done=%b, want 00000000 0", ram_a, if_done);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (if_done !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_done c%0d: got if_done=%b, want 0", c, if_done);
            end
        end
        test_byte_load(1'b0, 32'h00000080);
    endtask

    task automatic test_freeze();
        logic [7:0] exp_d [0:3];
        int         beat;
        int         w0;
        exp_d[0] = 8'h44;
        exp_d[1] = 8'h33;
        exp_d[2] = 8'h22;
        exp_d[3] = 8'h11;
        beat = 0;
        w0 = wr_count;
        mem_write = 1'b1;
        mem_len   = 2'd2;
        mem_addr  = 32'h40;
        mem_wdata = 32'h11223344;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 3) rdy = 1'b0;
            if (c == 6) rdy = 1'b1;
            #1;
            if (c >= 3 && c <= 5) begin
                checks++;
                if (ram_wr !== 1'b0 || mem_done !== 1'b0) begin
                    errors++;
                    $display("FAIL freeze_pause c%0d: got wr=%b done=%b, want 0 0", c, ram_wr, mem_done);
                end
            end else if (c <= 7) begin
                checks++;
                if (ram_wr !== 1'b1 || ram_a !== 32'h40 + 32'(beat) || ram_dout !== exp_d[beat]) begin
                    errors++;
                    $display("FAIL freeze_beat c%0d: got wr=%b a=%h d=%h, want 1 %h %h",
                             c, ram_wr, ram_a, ram_dout, 32'h40 + 32'(beat), exp_d[beat]);
                end
                beat++;
            end
            if (c != 3 && c != 4 && c != 5) begin
                checks++;
                if (mem_done !== (c == 8)) begin
                    errors++;
                    $display("FAIL freeze_done c%0d: got %b, want %b", c, mem_done, (c == 8));
                end
            end
        end
        mem_write = 1'b0;
        tick();
        tick();
        checks++;
        if (wr_count - w0 !== 4 || ram[16'h40] !== 8'h44 || ram[16'h43] !== 8'h11) begin
            errors++;
            $display("FAIL freeze_ram: got writes=%0d ram40=%h ram43=%h, want 4 44 11",
                     wr_count - w0, ram[16'h40], ram[16'h43]);
        end
    endtask

    task automatic test_reset_mid_read();
        if_req  = 1'b1;
        if_addr = 32'h100;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if_done, mem_done, ram_wr, ram_dout} !== 11'h0 || ram_a !== 32'h0 || if_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_read: got a=%h wr=%b done=%b/%b, want all zero",
                     ram_a, ram_wr, if_done, mem_done);
        end
        tick();
        tick();
        if_req = 1'b0;
        rst_n  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (if_done !== 1'b0 || ram_a !== 32'h0) begin
                errors++;
                $display("FAIL reset_no_done c%0d: got done=%b a=%h, want 0 00000000", c, if_done, ram_a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        poke(32'h2004, 8'h80);
        test_byte_load(1'b1, 32'hFFFFFF80);
        test_byte_load(1'b0, 32'h00000080);
        test_half_store();
        test_half_wrap();
        test_contention();
        test_flush();
        test_freeze();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
